// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared address map, I/O window nibble and seven-segment glyph table
package mmio_pkg;

  localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEYEDGE = 32'hF000_0110;

  localparam logic [3:0] IO_WINDOW = 4'hF;

  // Active-low segments, bit 0 = segment a, bit 6 = segment g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] glyph;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// rtl/mmio_ctrl_if.sv - CPU load/store bus into the memory-mapped I/O block
interface mmio_ctrl_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] ADDR;
  logic [DBITS-1:0] WDATA;
  logic             WE;
  logic [DBITS-1:0] RDATA;
  logic             HIT;

  modport master (output ADDR, output WDATA, output WE, input RDATA, input HIT);
  modport slave  (input ADDR, input WDATA, input WE, output RDATA, output HIT);
endinterface

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - two-flop synchronizer plus stability-counter debouncer for one input bit
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;

  // Any cycle where sync agrees with stable restarts the count, so short glitches never land.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign db = stable;

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - I/O window decode, LED/HEX registers, debounced KEY/SW reads; MMIO_KEY_EDGE_EN adds sticky KEYEDGE
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int                 DBITS           = 32,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter logic [DBITS-1:0]   ADDR_HEX        = DBITS'(mmio_pkg::ADDR_HEX),
  parameter logic [DBITS-1:0]   ADDR_LEDR       = DBITS'(mmio_pkg::ADDR_LEDR),
  parameter logic [DBITS-1:0]   ADDR_LEDG       = DBITS'(mmio_pkg::ADDR_LEDG),
  parameter logic [DBITS-1:0]   ADDR_KEY        = DBITS'(mmio_pkg::ADDR_KEY),
  parameter logic [DBITS-1:0]   ADDR_SW         = DBITS'(mmio_pkg::ADDR_SW)
) (
  input  logic        CLK,
  input  logic        RESET_N,
  mmio_ctrl_if.slave  bus,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [7:0]  LEDG,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  logic [15:0]      hexreg;
  logic [3:0]       key_db;
  logic [9:0]       sw_db;
  logic [13:0]      raw_in;
  logic [13:0]      db_out;
  logic             wr;
  logic [DBITS-1:0] rdata;

  assign bus.HIT = (bus.ADDR[DBITS-1 -: 4] == IO_WINDOW);
  assign wr      = bus.WE && bus.HIT;

  // Keys are active-low pushbuttons; invert up front so 1 means pressed everywhere downstream.
  assign raw_in = {SW, ~KEY};

  for (genvar i = 0; i < 14; i++) begin : g_db
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .raw     (raw_in[i]),
      .db      (db_out[i])
    );
  end

  assign key_db = db_out[3:0];
  assign sw_db  = db_out[13:4];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hexreg <= '0;
      LEDR   <= '0;
      LEDG   <= '0;
    end else if (wr) begin
      if (bus.ADDR == ADDR_HEX)  hexreg <= bus.WDATA[15:0];
      if (bus.ADDR == ADDR_LEDR) LEDR   <= bus.WDATA[9:0];
      if (bus.ADDR == ADDR_LEDG) LEDG   <= bus.WDATA[7:0];
    end
  end

`ifdef MMIO_KEY_EDGE_EN
  logic [3:0] key_db_q;
  logic [3:0] key_edge;
  logic [3:0] edge_clr;

  assign edge_clr = (wr && bus.ADDR == DBITS'(ADDR_KEYEDGE)) ? bus.WDATA[3:0] : 4'b0;

  // Set is OR-ed in after the clear so a same-cycle press survives a write-1-to-clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_db_q <= '0;
      key_edge <= '0;
    end else begin
      key_db_q <= key_db;
      key_edge <= (key_edge & ~edge_clr) | (key_db & ~key_db_q);
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (bus.ADDR == ADDR_HEX)       rdata = DBITS'(hexreg);
    else if (bus.ADDR == ADDR_LEDR) rdata = DBITS'(LEDR);
    else if (bus.ADDR == ADDR_LEDG) rdata = DBITS'(LEDG);
    else if (bus.ADDR == ADDR_KEY)  rdata = DBITS'(key_db);
    else if (bus.ADDR == ADDR_SW)   rdata = DBITS'(sw_db);
`ifdef MMIO_KEY_EDGE_EN
    else if (bus.ADDR == DBITS'(ADDR_KEYEDGE)) rdata = DBITS'(key_edge);
`endif
  end

  assign bus.RDATA = rdata;

  assign HEX0 = seg7(hexreg[3:0]);
  assign HEX1 = seg7(hexreg[7:4]);
  assign HEX2 = seg7(hexreg[11:8]);
  assign HEX3 = seg7(hexreg[15:12]);

  wire unused_wdata = ^bus.WDATA[DBITS-1:16];

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - scoreboard bench for mmio_ctrl with DEBOUNCE_CYCLES=4
module tb_mmio_ctrl;

  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;
  localparam logic [31:0] A_KE   = 32'hF000_0110;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [7:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  mmio_ctrl_if #(.DBITS(32)) bus ();

  mmio_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus),
    .KEY     (KEY),
    .SW      (SW),
    .LEDR    (LEDR),
    .LEDG    (LEDG),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3)
  );

  always #5 CLK = ~CLK;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          vectors = 0;
  int          miscompares = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", got, 32'hDEAD_DEAD);
    end else begin
      check_eq(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    bus.ADDR = addr;
    #1;
    pop_check(bus.RDATA);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.ADDR  = addr;
    bus.WDATA = data;
    bus.WE    = 1'b1;
    step();
    bus.WE    = 1'b0;
    #1;
  endtask

  task automatic check_hex(input logic [15:0] val);
    push("hex0", {25'b0, glyph[val[3:0]]});   pop_check({25'b0, HEX0});
    push("hex1", {25'b0, glyph[val[7:4]]});   pop_check({25'b0, HEX1});
    push("hex2", {25'b0, glyph[val[11:8]]});  pop_check({25'b0, HEX2});
    push("hex3", {25'b0, glyph[val[15:12]]}); pop_check({25'b0, HEX3});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N   = 1'b0;
    KEY       = 4'hF;
    SW        = 10'h0;
    bus.ADDR  = 32'h0;
    bus.WDATA = 32'h0;
    bus.WE    = 1'b0;
    repeat (3) step();

    push("rst_ledr", 32'h0); pop_check({22'b0, LEDR});
    push("rst_ledg", 32'h0); pop_check({24'b0, LEDG});
    check_hex(16'h0000);
    push("rst_key", 32'h0);  bus_read(A_KEY);
    RESET_N = 1'b1;
    step();

    bus_write(A_HEX, 32'h0000_BEEF);
    check_hex(16'hBEEF);
    bus_write(A_LEDR, 32'h0000_03FF);
    push("ledr_wr", 32'h3FF);      pop_check({22'b0, LEDR});
    push("hex_rd", 32'h0000_BEEF); bus_read(A_HEX);
    bus_write(A_LEDG, 32'hFFFF_FFA5);
    push("ledg_wr", 32'hA5);       pop_check({24'b0, LEDG});
    push("ledg_rd", 32'hA5);       bus_read(A_LEDG);

    bus_write(32'hF000_0020, 32'hFFFF_FFFF);
    push("unmapped_ledr", 32'h3FF); pop_check({22'b0, LEDR});
    check_hex(16'hBEEF);
    push("unmapped_rd", 32'h0);     bus_read(32'hF000_0020);
    push("unmapped_hit", 32'h1);    pop_check({31'b0, bus.HIT});
    bus_write(32'h0000_0004, 32'h0);
    push("nohit_ledr", 32'h3FF);    pop_check({22'b0, LEDR});
    push("nohit_hit", 32'h0);       pop_check({31'b0, bus.HIT});
    bus_write(A_SW, 32'h3FF);
    push("sw_ro", 32'h0);           bus_read(A_SW);

    SW = 10'h155;
    for (int i = 1; i <= 6; i++) begin
      step();
      push($sformatf("sw_db_c%0d", i), (i < 6) ? 32'h0 : 32'h155);
      bus_read(A_SW);
    end
    SW = 10'h154;
    repeat (3) step();
    SW = 10'h155;
    for (int i = 1; i <= 8; i++) begin
      step();
      push($sformatf("sw_glitch_c%0d", i), 32'h155);
      bus_read(A_SW);
    end

    KEY = 4'b1110;
    for (int i = 1; i <= 6; i++) begin
      step();
      push($sformatf("key_press_c%0d", i), (i < 6) ? 32'h0 : 32'h1);
      bus_read(A_KEY);
    end
    KEY = 4'b1111;
    for (int i = 1; i <= 6; i++) begin
      step();
      push($sformatf("key_rel_c%0d", i), (i < 6) ? 32'h1 : 32'h0);
      bus_read(A_KEY);
    end

    bus.ADDR  = A_LEDR;
    bus.WDATA = 32'h2A5;
    bus.WE    = 1'b1;
    #1;
    push("rd_during_wr_old", 32'h3FF); pop_check(bus.RDATA);
    step();
    bus.WE = 1'b0;
    push("rd_after_wr_new", 32'h2A5);  bus_read(A_LEDR);

    SW = 10'h0AA;
    repeat (3) step();
    #3;
    RESET_N = 1'b0;
    #1;
    push("async_ledr", 32'h0); pop_check({22'b0, LEDR});
    push("async_ledg", 32'h0); pop_check({24'b0, LEDG});
    check_hex(16'h0000);
    push("async_sw", 32'h0);   bus_read(A_SW);
    #1;
    RESET_N = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      push($sformatf("post_rst_sw_c%0d", i), (i < 6) ? 32'h0 : 32'h0AA);
      bus_read(A_SW);
    end

`ifdef MMIO_KEY_EDGE_EN
    KEY = 4'b1110;
    repeat (7) step();
    push("keyedge_k0", 32'h1); bus_read(A_KE);
    KEY = 4'b1100;
    repeat (6) step();
    push("keyedge_pre", 32'h1); bus_read(A_KE);
    bus_write(A_KE, 32'h1);
    push("keyedge_set_wins", 32'h2); bus_read(A_KE);
`else
    bus_write(A_KE, 32'hF);
    push("keyedge_absent", 32'h0); bus_read(A_KE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
